// File: rtl/alu_cmd_issuer_pkg.sv
// Issuer-local types: FSM state encoding.
package alu_cmd_issuer_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StResp  = 2'd2
  } state_e;

endpackage

// File: rtl/alu_pkg.sv
// ALU opcode encoding and flag-ownership helper shared by the ALU and its issuer.
package alu_pkg;

  typedef enum logic [3:0] {
    OpAnd  = 4'd0,
    OpOr   = 4'd1,
    OpAdd  = 4'd2,
    OpInc  = 4'd3,
    OpDec  = 4'd4,
    OpNot  = 4'd5,
    OpSub  = 4'd6,
    OpXor  = 4'd7,
    OpSl   = 4'd8,
    OpSr   = 4'd9,
    OpPass = 4'd10
  } alu_op_e;

  localparam logic [3:0] ALU_OP_MAX = 4'b1010;

  // Only carry-chain and shift ops define a carry worth keeping across commands.
  function automatic logic op_writes_carry(input logic [3:0] op);
    return (op == OpAdd) || (op == OpSub) || (op == OpSl) || (op == OpSr);
  endfunction

endpackage

// File: rtl/alu_cmd_issuer_if.sv
// Command and response valid/ready channels between a requester and the ALU issuer.
interface alu_cmd_issuer_if #(
  parameter int unsigned N = 4
) ();

  logic         cmd_valid;
  logic         cmd_ready;
  logic [3:0]   cmd_op;
  logic [N-1:0] cmd_a;
  logic [N-1:0] cmd_b;
  logic         cmd_use_carry;
  logic         carry_clr;

  logic         rsp_valid;
  logic         rsp_ready;
  logic [N-1:0] rsp_result;
  logic         rsp_cout;
  logic         rsp_z;
  logic         rsp_err;

  modport master (
    output cmd_valid, cmd_op, cmd_a, cmd_b, cmd_use_carry, carry_clr, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_result, rsp_cout, rsp_z, rsp_err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_a, cmd_b, cmd_use_carry, carry_clr, rsp_ready,
    output cmd_ready, rsp_valid, rsp_result, rsp_cout, rsp_z, rsp_err
  );

endinterface

// File: rtl/alu_cmd_issuer.sv
// Issues one ALU operation at a time, holds the ALU inputs for LAT cycles, and returns
// the captured flags/result; keeps the carry between commands for multi-word chains.
module alu_cmd_issuer
  import alu_pkg::*;
  import alu_cmd_issuer_pkg::*;
#(
  parameter int unsigned N   = 4,
  parameter int unsigned LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  alu_cmd_issuer_if.slave bus,
  output logic [N-1:0]  alu_a,
  output logic [N-1:0]  alu_b,
  output logic [3:0]    alu_ctrl,
  output logic          alu_flag_in,
  input  logic [N-1:0]  alu_result,
  input  logic          alu_cout,
  input  logic          alu_z,
  output logic          carry_q
);

  localparam int unsigned CntW = $clog2(LAT + 1);

  state_e          state_q;
  logic [CntW-1:0] cnt_q;

  assign bus.cmd_ready = (state_q == StIdle);
  assign bus.rsp_valid = (state_q == StResp);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= StIdle;
      cnt_q          <= '0;
      alu_a          <= '0;
      alu_b          <= '0;
      alu_ctrl       <= '0;
      alu_flag_in    <= 1'b0;
      bus.rsp_result <= '0;
      bus.rsp_cout   <= 1'b0;
      bus.rsp_z      <= 1'b0;
      bus.rsp_err    <= 1'b0;
      carry_q        <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.cmd_valid) begin
            if (bus.cmd_op <= ALU_OP_MAX) begin
              alu_a       <= bus.cmd_a;
              alu_b       <= bus.cmd_b;
              alu_ctrl    <= bus.cmd_op;
              alu_flag_in <= bus.cmd_use_carry & carry_q;
              cnt_q       <= CntW'(LAT - 1);
              state_q     <= StIssue;
            end else begin
              // Illegal op: answer immediately, leave the ALU pins untouched.
              bus.rsp_result <= '0;
              bus.rsp_cout   <= 1'b0;
              bus.rsp_z      <= 1'b0;
              bus.rsp_err    <= 1'b1;
              state_q        <= StResp;
            end
          end
        end
        StIssue: begin
          if (cnt_q == '0) begin
            bus.rsp_result <= alu_result;
            bus.rsp_cout   <= alu_cout;
            bus.rsp_z      <= alu_z;
            bus.rsp_err    <= 1'b0;
            if (op_writes_carry(alu_ctrl)) begin
              carry_q <= alu_cout;
            end
            state_q <= StResp;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        StResp: begin
          if (bus.rsp_ready) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
      // Placed last so it overrides a same-edge capture.
      if (bus.carry_clr) begin
        carry_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Drives two issuers (LAT=1 and LAT=4), each wired to a behavioural 4-bit ALU, and checks
// responses, pin hold, carry chaining and reset against a transaction-level model.
module tb_alu_cmd_issuer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_cmd_issuer_if #(.N(4)) bus1 ();
  alu_cmd_issuer_if #(.N(4)) bus4 ();

  logic       cv [2];
  logic       clr [2];
  logic       rr [2];
  logic [3:0] op_d, a_d, b_d;
  logic       uc_d;

  logic       rv [2], cr [2], rc [2], rz [2], rerr [2], cq [2], fin [2];
  logic [3:0] rres [2], aa [2], ab [2], actl [2];
  logic [3:0] alu_res [2];
  logic       alu_c [2], alu_zz [2];

  assign bus1.cmd_valid     = cv[0];
  assign bus1.cmd_op        = op_d;
  assign bus1.cmd_a         = a_d;
  assign bus1.cmd_b         = b_d;
  assign bus1.cmd_use_carry = uc_d;
  assign bus1.carry_clr     = clr[0];
  assign bus1.rsp_ready     = rr[0];
  assign bus4.cmd_valid     = cv[1];
  assign bus4.cmd_op        = op_d;
  assign bus4.cmd_a         = a_d;
  assign bus4.cmd_b         = b_d;
  assign bus4.cmd_use_carry = uc_d;
  assign bus4.carry_clr     = clr[1];
  assign bus4.rsp_ready     = rr[1];

  assign rv[0]   = bus1.rsp_valid;
  assign cr[0]   = bus1.cmd_ready;
  assign rc[0]   = bus1.rsp_cout;
  assign rz[0]   = bus1.rsp_z;
  assign rerr[0] = bus1.rsp_err;
  assign rres[0] = bus1.rsp_result;
  assign rv[1]   = bus4.rsp_valid;
  assign cr[1]   = bus4.cmd_ready;
  assign rc[1]   = bus4.rsp_cout;
  assign rz[1]   = bus4.rsp_z;
  assign rerr[1] = bus4.rsp_err;
  assign rres[1] = bus4.rsp_result;

  alu_cmd_issuer #(.N(4), .LAT(1)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1.slave),
    .alu_a(aa[0]), .alu_b(ab[0]), .alu_ctrl(actl[0]), .alu_flag_in(fin[0]),
    .alu_result(alu_res[0]), .alu_cout(alu_c[0]), .alu_z(alu_zz[0]), .carry_q(cq[0])
  );

  alu_cmd_issuer #(.N(4), .LAT(4)) dut4 (
    .clk(clk), .rst(rst), .bus(bus4.slave),
    .alu_a(aa[1]), .alu_b(ab[1]), .alu_ctrl(actl[1]), .alu_flag_in(fin[1]),
    .alu_result(alu_res[1]), .alu_cout(alu_c[1]), .alu_z(alu_zz[1]), .carry_q(cq[1])
  );

  // Behavioural ALU: returns {cout, z, result}.
  function automatic logic [5:0] alu_f(input logic [3:0] op, input logic [3:0] a,
                                       input logic [3:0] b, input logic fi);
    logic [4:0] s;
    case (op)
      4'd0:    s = {1'b0, a & b};
      4'd1:    s = {1'b0, a | b};
      4'd2:    s = {1'b0, a} + {1'b0, b} + {4'b0, fi};
      4'd3:    s = {1'b0, a} + 5'd1;
      4'd4:    s = {1'b0, a} - 5'd1;
      4'd5:    s = {1'b0, ~a};
      4'd6:    s = {1'b0, a} - {1'b0, b} - {4'b0, fi};
      4'd7:    s = {1'b0, a ^ b};
      4'd8:    s = {a, 1'b0};
      4'd9:    s = {a[0], 1'b0, a[3:1]};
      4'd10:   s = {1'b0, a};
      default: s = 5'd0;
    endcase
    return {s[4], (s[3:0] == 4'd0), s[3:0]};
  endfunction

  always_comb {alu_c[0], alu_zz[0], alu_res[0]} = alu_f(actl[0], aa[0], ab[0], fin[0]);
  always_comb {alu_c[1], alu_zz[1], alu_res[1]} = alu_f(actl[1], aa[1], ab[1], fin[1]);

  int tests = 0;
  int fails = 0;

  logic       ref_carry [2];
  logic [3:0] exp_a [2], exp_b [2], exp_ctrl [2];
  logic       exp_fin [2];

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    for (int k = 0; k < 2; k++) begin
      ref_carry[k] = 1'b0;
      exp_a[k]     = 4'd0;
      exp_b[k]     = 4'd0;
      exp_ctrl[k]  = 4'd0;
      exp_fin[k]   = 1'b0;
    end
  endtask

  task automatic do_cmd(input int w, input logic [3:0] op, input logic [3:0] a,
                        input logic [3:0] b, input logic uc, input logic clr_cap,
                        input int hold);
    int         lat;
    int         n;
    logic       legal;
    logic       ef;
    logic [5:0] r;
    lat   = (w == 1) ? 4 : 1;
    legal = (op <= 4'd10);
    @(negedge clk);
    chk("cmd_ready_idle", {7'd0, cr[w]}, 8'd1);
    op_d = op; a_d = a; b_d = b; uc_d = uc; cv[w] = 1'b1;
    @(posedge clk); #1;
    cv[w] = 1'b0;
    n = 0;
    while (rv[w] !== 1'b1 && n < 20) begin
      if (clr_cap && legal && n == lat - 1) clr[w] = 1'b1;
      @(posedge clk); #1;
      clr[w] = 1'b0;
      n++;
    end
    if (legal) begin
      ef = uc & ref_carry[w];
      r  = alu_f(op, a, b, ef);
      exp_a[w] = a; exp_b[w] = b; exp_ctrl[w] = op; exp_fin[w] = ef;
      if (op inside {4'd2, 4'd6, 4'd8, 4'd9}) ref_carry[w] = r[5];
      if (clr_cap) ref_carry[w] = 1'b0;
    end else begin
      r = 6'd0;
    end
    chk("latency", 8'(n), legal ? 8'(lat) : 8'd0);
    chk("rsp_result", {4'd0, rres[w]}, {4'd0, r[3:0]});
    chk("rsp_cout", {7'd0, rc[w]}, {7'd0, r[5]});
    chk("rsp_z", {7'd0, rz[w]}, {7'd0, r[4]});
    chk("rsp_err", {7'd0, rerr[w]}, {7'd0, !legal});
    chk("carry_q", {7'd0, cq[w]}, {7'd0, ref_carry[w]});
    chk("alu_a", {4'd0, aa[w]}, {4'd0, exp_a[w]});
    chk("alu_b", {4'd0, ab[w]}, {4'd0, exp_b[w]});
    chk("alu_ctrl", {4'd0, actl[w]}, {4'd0, exp_ctrl[w]});
    chk("alu_flag_in", {7'd0, fin[w]}, {7'd0, exp_fin[w]});
    if (hold > 0) begin
      for (int i = 0; i < hold; i++) begin
        if (i == 1) begin
          op_d = 4'd3; a_d = ~exp_a[w]; cv[w] = 1'b1;
        end
        @(posedge clk); #1;
        cv[w] = 1'b0;
      end
      chk("hold_cmd_ready", {7'd0, cr[w]}, 8'd0);
      chk("hold_rsp_valid", {7'd0, rv[w]}, 8'd1);
      chk("hold_rsp_result", {4'd0, rres[w]}, {4'd0, r[3:0]});
      chk("hold_alu_a", {4'd0, aa[w]}, {4'd0, exp_a[w]});
    end
    rr[w] = 1'b1;
    @(posedge clk); #1;
    rr[w] = 1'b0;
    chk("back_to_idle", {7'd0, cr[w]}, 8'd1);
    chk("rsp_valid_drop", {7'd0, rv[w]}, 8'd0);
  endtask

  initial begin
    logic seen;
    for (int k = 0; k < 2; k++) begin
      cv[k] = 1'b0; clr[k] = 1'b0; rr[k] = 1'b0;
    end
    op_d = 4'd0; a_d = 4'd0; b_d = 4'd0; uc_d = 1'b0;
    clear_model();
    #12;
    for (int k = 0; k < 2; k++) begin
      chk("rst_cmd_ready", {7'd0, cr[k]}, 8'd1);
      chk("rst_rsp_valid", {7'd0, rv[k]}, 8'd0);
      chk("rst_alu_a", {4'd0, aa[k]}, 8'd0);
      chk("rst_carry_q", {7'd0, cq[k]}, 8'd0);
    end
    @(negedge clk);
    rst = 1'b0;

    do_cmd(0, 4'd2, 4'h7, 4'h8, 1'b0, 1'b0, 0);   // 7+8 = F
    do_cmd(0, 4'd2, 4'hF, 4'h1, 1'b0, 1'b0, 0);   // wraps, carry out 1
    do_cmd(0, 4'd2, 4'h0, 4'h0, 1'b1, 1'b0, 0);   // carry in 1 -> result 1
    do_cmd(0, 4'd7, 4'hA, 4'h6, 1'b0, 1'b0, 5);   // stalled response, ignored pulse
    do_cmd(0, 4'd2, 4'hF, 4'h1, 1'b0, 1'b0, 0);   // carry 1 before illegal op
    do_cmd(0, 4'b1100, 4'h3, 4'h4, 1'b0, 1'b0, 0);
    do_cmd(0, 4'd2, 4'hF, 4'h1, 1'b0, 1'b1, 0);   // clear wins over capture
    do_cmd(1, 4'd6, 4'h3, 4'h5, 1'b0, 1'b0, 0);
    do_cmd(1, 4'd2, 4'hF, 4'h1, 1'b0, 1'b0, 2);

    for (int i = 0; i < 36; i++) begin
      do_cmd((i % 3 == 2) ? 1 : 0, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
             4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
             ($urandom_range(0, 3) == 0), $urandom_range(0, 2));
    end

    // Reset in the middle of a LAT=4 issue.
    do_cmd(1, 4'd2, 4'hF, 4'h1, 1'b0, 1'b0, 0);
    @(negedge clk);
    op_d = 4'd2; a_d = 4'h5; b_d = 4'h6; uc_d = 1'b0; cv[1] = 1'b1;
    @(posedge clk); #1;
    cv[1] = 1'b0;
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    chk("mid_rst_cmd_ready", {7'd0, cr[1]}, 8'd1);
    chk("mid_rst_rsp_valid", {7'd0, rv[1]}, 8'd0);
    chk("mid_rst_alu_a", {4'd0, aa[1]}, 8'd0);
    chk("mid_rst_alu_b", {4'd0, ab[1]}, 8'd0);
    chk("mid_rst_alu_ctrl", {4'd0, actl[1]}, 8'd0);
    chk("mid_rst_flag_in", {7'd0, fin[1]}, 8'd0);
    chk("mid_rst_carry_q", {7'd0, cq[1]}, 8'd0);
    chk("mid_rst_rsp_result", {4'd0, rres[1]}, 8'd0);
    @(negedge clk);
    rst = 1'b0;
    clear_model();
    seen = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
      if (rv[1] === 1'b1) seen = 1'b1;
    end
    chk("no_rsp_after_rst", {7'd0, seen}, 8'd0);
    do_cmd(1, 4'd8, 4'h9, 4'h0, 1'b0, 1'b0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
